// File: rtl/fb_arbiter_pkg.sv
// fb_arbiter_pkg: shared op encodings, FSM states and framebuffer geometry
package fb_arbiter_pkg;
  localparam int FB_W = 64;
  localparam int FB_H = 32;
  localparam int FB_BYTES = 256;
  localparam int AW = 8;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_CLEAR = 2'b01, OP_DRAW = 2'b10} op_e;
  typedef enum logic [3:0] {S_IDLE, S_CLEAR, S_FETCH, S_RD_L, S_RD_R, S_WR_L, S_WR_R, S_NEXT, S_DONE} state_e;
endpackage

// File: rtl/fb_ram.sv
// fb_ram: 256x8 single-port RAM, synchronous read, write-first, no reset
module fb_ram import fb_arbiter_pkg::*; (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wd,
  output logic [7:0]    rd
);
  logic [7:0] mem [FB_BYTES];
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wd;
      rd <= wd;
    end else rd <= mem[addr];
  end
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: framebuffer RAM owner; VGA reads win, sprite XOR sequencer stalls.
// Define FB_CLIP_EN to clip sprites at the right and bottom edges instead of wrapping.
module fb_arbiter import fb_arbiter_pkg::*; #(
  parameter logic [7:0] CLEAR_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vga_rd_en,
  input  logic [7:0] vga_rd_addr,
  output logic [7:0] vga_rd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_x,
  input  logic [4:0] cmd_y,
  input  logic [3:0] cmd_n,
  input  logic       spr_valid,
  output logic       spr_ready,
  input  logic [7:0] spr_data,
  output logic       done,
  output logic       collision,
  output logic       busy
);
  state_e state;
  logic [5:0] x;
  logic [4:0] y, row;
  logic [3:0] n, i;
  logic [2:0] sh;
  logic [7:0] cnt, spr_l, spr_r, old_l, old_r, old_l_v, old_r_v;
  logic [7:0] ram_addr, ram_wd, ram_rd, vga_hold, addr_l, addr_r;
  logic ram_we, grant, vga_pend, cap_l, cap_r, has_r, row_ok;
  assign sh = x[2:0];
  assign grant = !vga_rd_en;
  assign row = y + {1'b0, i};
  assign addr_l = {row, x[5:3]};
  assign addr_r = {row, x[5:3] + 3'd1};
`ifdef FB_CLIP_EN
  logic [5:0] row_sum;
  assign row_sum = {1'b0, y} + {2'b0, i};
  assign row_ok = !row_sum[5];
  assign has_r = sh != 3'd0 && x[5:3] != 3'd7;
`else
  assign row_ok = 1'b1;
  assign has_r = sh != 3'd0;
`endif
  assign cmd_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign spr_ready = state == S_FETCH;
  assign done = state == S_DONE;
  // Read data lands one cycle after the granted read even if VGA grabs the RAM in between
  assign old_l_v = cap_l ? ram_rd : old_l;
  assign old_r_v = cap_r ? ram_rd : old_r;
  assign vga_rd_data = vga_pend ? ram_rd : vga_hold;
  always_comb begin
    ram_we = grant && (state == S_CLEAR || state == S_WR_L || state == S_WR_R);
    ram_addr = vga_rd_en ? vga_rd_addr : state == S_CLEAR ? cnt : (state == S_RD_R || state == S_WR_R) ? addr_r : addr_l;
    ram_wd = state == S_CLEAR ? CLEAR_VAL : state == S_WR_L ? old_l_v ^ spr_l : old_r_v ^ spr_r;
  end
  fb_ram u_ram (.clk(clk), .we(ram_we), .addr(ram_addr), .wd(ram_wd), .rd(ram_rd));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      vga_pend <= 1'b0;
      vga_hold <= 8'h00;
      cap_l <= 1'b0;
      cap_r <= 1'b0;
      collision <= 1'b0;
      x <= '0;
      y <= '0;
      n <= '0;
      i <= '0;
      cnt <= '0;
      spr_l <= '0;
      spr_r <= '0;
      old_l <= '0;
      old_r <= '0;
    end else begin
      vga_pend <= vga_rd_en;
      if (vga_pend) vga_hold <= ram_rd;
      cap_l <= grant && state == S_RD_L;
      cap_r <= grant && state == S_RD_R;
      if (cap_l) old_l <= ram_rd;
      if (cap_r) old_r <= ram_rd;
      case (state)
        S_IDLE: if (cmd_valid) begin
          x <= cmd_x;
          y <= cmd_y;
          n <= cmd_n;
          i <= '0;
          cnt <= '0;
          if (cmd_op == OP_DRAW) collision <= 1'b0;
          state <= cmd_op == OP_CLEAR ? S_CLEAR : (cmd_op == OP_DRAW && cmd_n != 4'd0) ? S_FETCH : S_DONE;
        end
        S_CLEAR: if (grant) begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'hFF) state <= S_DONE;
        end
        S_FETCH: if (spr_valid) begin
          spr_l <= spr_data >> sh;
          spr_r <= spr_data << (4'd8 - {1'b0, sh});
          state <= row_ok ? S_RD_L : S_NEXT;
        end
        S_RD_L: if (grant) state <= has_r ? S_RD_R : S_WR_L;
        S_RD_R: if (grant) state <= S_WR_L;
        S_WR_L: if (grant) begin
          if ((old_l_v & spr_l) != 8'h00) collision <= 1'b1;
          state <= has_r ? S_WR_R : S_NEXT;
        end
        S_WR_R: if (grant) begin
          if ((old_r_v & spr_r) != 8'h00) collision <= 1'b1;
          state <= S_NEXT;
        end
        S_NEXT: begin
          i <= i + 4'd1;
          state <= (i + 4'd1 == n) ? S_DONE : S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed self-checking bench for fb_arbiter (honours FB_CLIP_EN)
module tb_fb_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic vga_rd_en = 1'b0;
  logic [7:0] vga_rd_addr = '0, vga_rd_data;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [5:0] cmd_x = '0;
  logic [4:0] cmd_y = '0;
  logic [3:0] cmd_n = '0;
  logic spr_valid = 1'b0, spr_ready;
  logic [7:0] spr_data = '0;
  logic done, collision, busy;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  fb_arbiter dut (
    .clk(clk), .rst(rst), .vga_rd_en(vga_rd_en), .vga_rd_addr(vga_rd_addr), .vga_rd_data(vga_rd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n),
    .spr_valid(spr_valid), .spr_ready(spr_ready), .spr_data(spr_data),
    .done(done), .collision(collision), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic vga_read(input logic [7:0] a, output logic [7:0] d);
    vga_rd_en = 1'b1;
    vga_rd_addr = a;
    step();
    vga_rd_en = 1'b0;
    d = vga_rd_data;
  endtask
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] x, input logic [4:0] y, input logic [3:0] n,
                         input logic [7:0] s0, input logic [7:0] s1, output int cyc);
    int k;
    k = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_x = x;
    cmd_y = y;
    cmd_n = n;
    step();
    cmd_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 1000) begin
      spr_valid = spr_ready;
      spr_data = (k == 0) ? s0 : s1;
      step();
      if (spr_valid) k++;
      spr_valid = 1'b0;
      cyc++;
    end
    check("cmd_timeout", done, 1);
    step();
    check("done_pulse", done, 0);
  endtask
  // Framebuffer contents right after the x=60 wrap/clip draw
  function automatic logic [7:0] mem_exp(input logic [7:0] a);
`ifdef FB_CLIP_EN
    return a == 8'd255 ? 8'h0F : 8'h00;
`else
    return a == 8'd255 ? 8'h0F : a == 8'd248 ? 8'hF0 : a == 8'd7 ? 8'h08 : a == 8'd0 ? 8'h10 : 8'h00;
`endif
  endfunction
  initial begin
    int cyc, bad;
    logic [7:0] d, a;
    step();
    step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_spr_ready", spr_ready, 0);
    check("rst_done", done, 0);
    check("rst_collision", collision, 0);
    check("rst_vga_data", vga_rd_data, 8'h00);
    rst = 1'b0;
    step();
    run_cmd(2'b01, 6'd0, 5'd0, 4'd0, 8'h00, 8'h00, cyc);
    check("clear_latency", cyc, 257);
    bad = 0;
    for (int j = 0; j < 256; j++) begin
      vga_read(8'(j), d);
      if (d !== 8'h00) bad++;
    end
    check("clear_all_zero", bad, 0);
    check("clear_collision", collision, 0);
    run_cmd(2'b10, 6'd0, 5'd0, 4'd1, 8'hF0, 8'h00, cyc);
    vga_read(8'd0, d);
    check("draw1_addr0", d, 8'hF0);
    check("draw1_coll", collision, 0);
    check("draw1_latency", cyc, 5);
    run_cmd(2'b10, 6'd0, 5'd0, 4'd1, 8'hF0, 8'h00, cyc);
    vga_read(8'd0, d);
    check("draw2_addr0", d, 8'h00);
    check("draw2_coll", collision, 1);
    run_cmd(2'b10, 6'd60, 5'd31, 4'd2, 8'hFF, 8'h81, cyc);
    vga_read(8'd255, d);
    check("wrap_addr255", d, 8'h0F);
    vga_read(8'd248, d);
    check("wrap_addr248", d, mem_exp(8'd248));
    vga_read(8'd7, d);
    check("wrap_addr7", d, mem_exp(8'd7));
    vga_read(8'd0, d);
    check("wrap_addr0", d, mem_exp(8'd0));
    check("wrap_coll", collision, 0);
`ifdef FB_CLIP_EN
    check("wrap_latency", cyc, 7);
`else
    check("wrap_latency", cyc, 13);
`endif
    vga_read(8'd255, d);
    step();
    step();
    step();
    check("vga_hold", vga_rd_data, 8'h0F);
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    cmd_x = 6'd3;
    cmd_y = 5'd5;
    cmd_n = 4'd1;
    step();
    cmd_valid = 1'b0;
    check("stall_spr_ready", spr_ready, 1);
    spr_valid = 1'b1;
    spr_data = 8'hAA;
    step();
    spr_valid = 1'b0;
    bad = 0;
    for (int t = 0; t < 100; t++) begin
      a = t < 60 ? ((t % 4 == 0) ? 8'd0 : (t % 4 == 1) ? 8'd7 : (t % 4 == 2) ? 8'd248 : 8'd255) : 8'(t);
      vga_rd_en = 1'b1;
      vga_rd_addr = a;
      step();
      if (vga_rd_data !== mem_exp(a) || done || !busy) bad++;
    end
    check("stall_reads", bad, 0);
    vga_rd_en = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    check("stall_release_lat", cyc, 5);
    step();
    vga_read(8'd40, d);
    check("stall_addr40", d, 8'h15);
    vga_read(8'd41, d);
    check("stall_addr41", d, 8'h40);
    check("stall_coll", collision, 0);
    run_cmd(2'b10, 6'd0, 5'd0, 4'd1, 8'h10, 8'h00, cyc);
    vga_read(8'd0, d);
`ifdef FB_CLIP_EN
    check("redraw_addr0", d, 8'h10);
    check("redraw_coll", collision, 0);
`else
    check("redraw_addr0", d, 8'h00);
    check("redraw_coll", collision, 1);
`endif
    run_cmd(2'b11, 6'd0, 5'd0, 4'd1, 8'hFF, 8'h00, cyc);
    check("nop_latency", cyc, 1);
    vga_read(8'd0, d);
`ifdef FB_CLIP_EN
    check("nop_addr0", d, 8'h10);
    check("nop_coll_hold", collision, 0);
`else
    check("nop_addr0", d, 8'h00);
    check("nop_coll_hold", collision, 1);
`endif
    run_cmd(2'b10, 6'd0, 5'd0, 4'd0, 8'hFF, 8'h00, cyc);
    check("n0_latency", cyc, 1);
    check("n0_coll", collision, 0);
    vga_read(8'd255, d);
    check("n0_addr255", d, 8'h0F);
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    cmd_x = 6'd0;
    cmd_y = 5'd2;
    cmd_n = 4'd1;
    step();
    cmd_valid = 1'b0;
    spr_valid = 1'b1;
    spr_data = 8'h01;
    step();
    spr_valid = 1'b0;
    step();
    check("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_coll", collision, 0);
    check("rst_mid_done", done, 0);
    step();
    check("rst_mid_done_next", done, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
